result_bus_arbiter: RTL and testbench

Collects finished results from the reservation stations (integer units and peers) and drives them onto the shared result buses. Each cycle it selects up to BUS_COUNT ready stations in round-robin order and registers their results onto the buses. It pulses a per-station release so dispatch can free the station. It sits directly downstream of every station's result_ready/result pair and upstream of every StationParameter snooping the bus.

---
 rtl/result_bus_arbiter.sv | 106 ++++++++++
 tb/tb_result_bus_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/result_bus_arbiter.sv
// ============================================================================
// result_bus_arbiter: round-robin grant of ready stations onto result buses
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_bus_arbiter #(
  parameter int SIZE               = 32,
  parameter int STATION_COUNT      = 4,
  parameter int STATION_INDEX_SIZE = 2,
  parameter int BUS_COUNT          = 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic [STATION_COUNT-1:0]                station_ready_flat,
  input  logic [SIZE*STATION_COUNT-1:0]           station_result_flat,
  output logic [STATION_COUNT-1:0]                station_release,
  output logic [BUS_COUNT-1:0]                    bus_asserted_flat,
  output logic [STATION_INDEX_SIZE*BUS_COUNT-1:0] bus_source_flat,
  output logic [SIZE*BUS_COUNT-1:0]               bus_value_flat
);

  localparam int IW = STATION_INDEX_SIZE;

  typedef logic [IW-1:0] idx_t;

  // (base + offset) mod STATION_COUNT; offset is always below STATION_COUNT
  function automatic idx_t wrap_add(input idx_t base, input int offset);
    logic [IW:0] sum;
    sum = {1'b0, base} + (IW+1)'(offset);
    if (sum >= (IW+1)'(STATION_COUNT)) begin
      sum = sum - (IW+1)'(STATION_COUNT);
    end
    return sum[IW-1:0];
  endfunction

  idx_t                     ptr;
  idx_t                     ptr_next;
  idx_t                     sel       [BUS_COUNT];
  logic [BUS_COUNT-1:0]     sel_valid;
  logic [STATION_COUNT-1:0] release_next;
  logic [SIZE-1:0]          result_arr [STATION_COUNT];

  generate
    for (genvar s = 0; s < STATION_COUNT; s++) begin : g_unpack
      assign result_arr[s] = station_result_flat[s*SIZE +: SIZE];
    end
  endgenerate

  // Each bus takes the next still-unclaimed eligible station in scan order;
  // stations pulsing release this cycle are excluded to avoid double grants.
  always_comb begin : select_proc
    logic [STATION_COUNT-1:0] remaining;
    idx_t                     idx;
    idx_t                     last;
    logic                     any;
    remaining    = station_ready_flat & ~station_release;
    release_next = '0;
    sel_valid    = '0;
    last         = '0;
    any          = 1'b0;
    idx          = '0;
    for (int k = 0; k < BUS_COUNT; k++) begin
      sel[k] = '0;
      for (int i = 0; i < STATION_COUNT; i++) begin
        idx = wrap_add(ptr, i);
        if (!sel_valid[k] && remaining[idx]) begin
          sel_valid[k]      = 1'b1;
          sel[k]            = idx;
          remaining[idx]    = 1'b0;
          release_next[idx] = 1'b1;
          last              = idx;
          any               = 1'b1;
        end
      end
    end
    ptr_next = any ? wrap_add(last, 1) : ptr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr               <= '0;
      station_release   <= '0;
      bus_asserted_flat <= '0;
      bus_source_flat   <= '0;
      bus_value_flat    <= '0;
    end else if (flush) begin
      station_release   <= '0;
      bus_asserted_flat <= '0;
      bus_source_flat   <= '0;
      bus_value_flat    <= '0;
    end else begin
      ptr             <= ptr_next;
      station_release <= release_next;
      for (int k = 0; k < BUS_COUNT; k++) begin
        bus_asserted_flat[k]        <= sel_valid[k];
        bus_source_flat[k*IW +: IW] <= sel[k];
        bus_value_flat[k*SIZE +: SIZE] <= sel_valid[k] ? result_arr[sel[k]] : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: a 1-bus, a 2-bus and a 3-station instance.
`default_nettype none

module tb_result_bus_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] R0 = 32'h1111_0000;
  localparam logic [31:0] R1 = 32'h2222_0001;
  localparam logic [31:0] R2 = 32'hDEAD_BEEF;
  localparam logic [31:0] R3 = 32'h4444_0003;

  // instance A: 4 stations, 1 bus
  logic         a_reset = 1'b1, a_flush = 1'b0;
  logic [3:0]   a_ready = 4'b0;
  logic [127:0] a_result;
  logic [3:0]   a_release;
  logic [0:0]   a_asserted;
  logic [1:0]   a_source;
  logic [31:0]  a_value;

  // instance B: 4 stations, 2 buses
  logic         b_reset = 1'b1, b_flush = 1'b0;
  logic [3:0]   b_ready = 4'b0;
  logic [127:0] b_result;
  logic [3:0]   b_release;
  logic [1:0]   b_asserted;
  logic [3:0]   b_source;
  logic [63:0]  b_value;

  // instance C: 3 stations, 1 bus
  logic         c_reset = 1'b1, c_flush = 1'b0;
  logic [2:0]   c_ready = 3'b0;
  logic [95:0]  c_result;
  logic [2:0]   c_release;
  logic [0:0]   c_asserted;
  logic [1:0]   c_source;
  logic [31:0]  c_value;

  assign a_result = {R3, R2, R1, R0};
  assign b_result = {R3, R2, R1, R0};
  assign c_result = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000};

  result_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .STATION_INDEX_SIZE(2), .BUS_COUNT(1)) u_a (
    .clock(clock), .reset(a_reset), .flush(a_flush),
    .station_ready_flat(a_ready), .station_result_flat(a_result),
    .station_release(a_release), .bus_asserted_flat(a_asserted),
    .bus_source_flat(a_source), .bus_value_flat(a_value));

  result_bus_arbiter #(.SIZE(32), .STATION_COUNT(4), .STATION_INDEX_SIZE(2), .BUS_COUNT(2)) u_b (
    .clock(clock), .reset(b_reset), .flush(b_flush),
    .station_ready_flat(b_ready), .station_result_flat(b_result),
    .station_release(b_release), .bus_asserted_flat(b_asserted),
    .bus_source_flat(b_source), .bus_value_flat(b_value));

  result_bus_arbiter #(.SIZE(32), .STATION_COUNT(3), .STATION_INDEX_SIZE(2), .BUS_COUNT(1)) u_c (
    .clock(clock), .reset(c_reset), .flush(c_flush),
    .station_ready_flat(c_ready), .station_result_flat(c_result),
    .station_release(c_release), .bus_asserted_flat(c_asserted),
    .bus_source_flat(c_source), .bus_value_flat(c_value));

  typedef struct {
    logic        rst;
    logic        fl;
    logic [3:0]  rdy;
    logic [3:0]  rel;
    logic        asrt;
    logic [1:0]  src;
    logic [31:0] val;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // inputs applied before the edge -> outputs expected just after it
    vecs[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, R0};
    vecs[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, R1};
    vecs[4]  = '{1'b0, 1'b0, 4'b1110, 4'b0100, 1'b1, 2'd2, R2};
    vecs[5]  = '{1'b0, 1'b0, 4'b1100, 4'b1000, 1'b1, 2'd3, R3};
    vecs[6]  = '{1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 4'b1010, 4'b0010, 1'b1, 2'd1, R1};
    vecs[8]  = '{1'b0, 1'b0, 4'b1010, 4'b1000, 1'b1, 2'd3, R3};
    vecs[9]  = '{1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, R2};
    vecs[12] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[15] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, R1};
    vecs[16] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, R0};
    vecs[18] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 32'h0};
    vecs[19] = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, R0};

    for (int i = 0; i < 20; i++) begin
      a_reset = vecs[i].rst;
      a_flush = vecs[i].fl;
      a_ready = vecs[i].rdy;
      step();
      check($sformatf("A_vec%0d {rel,asrt,src,val}", i),
            {89'd0, a_release, a_asserted, a_source, a_value},
            {89'd0, vecs[i].rel, vecs[i].asrt, vecs[i].src, vecs[i].val});
    end
    a_reset = 1'b1;
    a_ready = 4'b0;

    // dual bus: drive ptr to 3, then grant across the wrap
    b_reset = 1'b1; b_ready = 4'b1111;
    step();
    check("B_reset", {b_release, b_asserted, b_source, b_value},
          {4'b0000, 2'b00, 4'b0000, 64'h0});
    b_reset = 1'b0; b_ready = 4'b0100;
    step();
    check("B_grant2", {b_release, b_asserted, b_source, b_value},
          {4'b0100, 2'b01, 4'b0010, 32'h0, R2});
    b_ready = 4'b1011;
    step();
    check("B_wrap_3_0", {b_release, b_asserted, b_source, b_value},
          {4'b1001, 2'b11, 4'b0011, R0, R3});
    step();
    check("B_then_1", {b_release, b_asserted, b_source, b_value},
          {4'b0010, 2'b01, 4'b0001, 32'h0, R1});
    b_ready = 4'b0010;
    step();
    check("B_masked", {b_release, b_asserted, b_source, b_value},
          {4'b0000, 2'b00, 4'b0000, 64'h0});
    b_reset = 1'b1;
    b_ready = 4'b0;

    // three stations, all ready continuously: sources cycle 0,1,2,0,...
    c_reset = 1'b1; c_ready = 3'b111;
    step();
    check("C_reset", {c_release, c_asserted, c_source, c_value}, {3'b000, 1'b0, 2'd0, 32'h0});
    c_reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      logic [1:0] es;
      es = 2'(i % 3);
      step();
      check($sformatf("C_rr%0d {rel,asrt,src,val}", i),
            {c_release, c_asserted, c_source, c_value},
            {3'b001 << es, 1'b1, es, 32'hC000_0000 + 32'(es)});
    end
    c_reset = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
